cci_test_csrs_mux: RTL and testbench

Parametrised MMIO CSR manager for CCI test AFUs. It decodes the MMIO address window, serves the AFU DFH, AFU ID, clock frequency, a configurable bank of event counters and NUM_TEST_CSRS test CSRs. It merges its own read responses with read responses produced by downstream AFU logic through a response queue, so a local read and an AFU-owned read can be outstanding at the same time without either being lost. It sits between the FIU MMIO path and the test engine, and adds clearable and read-clear counters.

---
 rtl/cci_test_csrs_mux.sv | 161 ++++++++++++++++
 tb/tb_cci_test_csrs_mux.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_test_csrs_mux.sv
// MMIO CSR manager for CCI test AFUs: DFH/ID/frequency/event counters/test CSRs,
// with local read responses queued behind AFU-owned responses on one return path.
module cci_test_csrs_mux #(
  parameter int           NUM_TEST_CSRS        = 8,
  parameter int           TEST_CSR_BASE        = 32,
  parameter int           NUM_CTRS             = 7,
  parameter int           CTR_WIDTH            = 48,
  parameter int           CTR_READ_CLEAR       = 0,
  parameter int           RSP_FIFO_DEPTH       = 4,
  parameter logic [23:0]  NEXT_DFH_BYTE_OFFSET = 24'h0,
  parameter logic [127:0] AFU_ID               = 128'h438d6c19_ff0c_40da_a43d_1f18bf214d19,
  parameter int           CLK_FREQ_MHZ         = 400
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mmio_valid,
  input  logic                       mmio_is_read,
  input  logic [15:0]                mmio_addr,
  input  logic [8:0]                 mmio_tid,
  input  logic [63:0]                mmio_wdata,
  input  logic                       afu_rsp_valid,
  input  logic [8:0]                 afu_rsp_tid,
  input  logic [63:0]                afu_rsp_data,
  output logic                       rsp_valid,
  output logic [8:0]                 rsp_tid,
  output logic [63:0]                rsp_data,
  input  logic [NUM_CTRS-1:0]        evt,
  input  logic [64*NUM_TEST_CSRS-1:0] csr_rd_data,
  output logic [NUM_TEST_CSRS-1:0]   csr_wr_en,
  output logic [63:0]                csr_wr_data,
  output logic                       rsp_overflow
);
  // Handshake: every valid here is a one-cycle strobe with no ready; the FIU
  // and AFU never stall us and we never stall them, so overflow is reported, not backpressured.

  localparam int IDX_W = 15;
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam logic [IDX_W-1:0] CLAIM_LIMIT = IDX_W'(TEST_CSR_BASE + NUM_TEST_CSRS);
  localparam logic [63:0] DFH = {4'h1, 19'b0, (NEXT_DFH_BYTE_OFFSET == 24'h0),
                                 NEXT_DFH_BYTE_OFFSET, 4'h0, 12'h0};

  logic             s0_valid, s0_is_read;
  logic [IDX_W-1:0] s0_idx;
  logic [8:0]       s0_tid;
  logic [63:0]      s0_wdata;
  logic             addr_unused;

  assign addr_unused = mmio_addr[0];

  always_ff @(posedge clk) begin
    if (!reset_n) s0_valid <= 1'b0;
    else          s0_valid <= mmio_valid && (mmio_addr[15:1] < CLAIM_LIMIT);
    s0_is_read <= mmio_is_read;
    s0_idx     <= mmio_addr[15:1];
    s0_tid     <= mmio_tid;
    s0_wdata   <= mmio_wdata;
  end

  logic                     rd_fire, wr_fire, ctr_clear;
  logic [63:0]              rd_data;
  logic [NUM_CTRS-1:0]      ctr_sel;
  logic [NUM_TEST_CSRS-1:0] test_sel;
  logic [CTR_WIDTH-1:0]     ctr_q [NUM_CTRS];

  assign rd_fire   = s0_valid && s0_is_read;
  assign wr_fire   = s0_valid && !s0_is_read;
  assign ctr_clear = wr_fire && (s0_idx == IDX_W'(7)) && s0_wdata[0];

  always_comb begin
    rd_data  = '0;
    ctr_sel  = '0;
    test_sel = '0;
    case (s0_idx)
      IDX_W'(0): rd_data = DFH;
      IDX_W'(1): rd_data = AFU_ID[63:0];
      IDX_W'(2): rd_data = AFU_ID[127:64];
      IDX_W'(8): rd_data = 64'(CLK_FREQ_MHZ);
      default:   rd_data = '0;
    endcase
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (s0_idx == IDX_W'(9 + i)) begin
        rd_data    = 64'(ctr_q[i]);
        ctr_sel[i] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_TEST_CSRS; j++) begin
      if (s0_idx == IDX_W'(TEST_CSR_BASE + j)) begin
        rd_data     = csr_rd_data[64*j +: 64];
        test_sel[j] = 1'b1;
      end
    end
  end

  // Clear beats increment; a read-clear reloads with this cycle's event so none is lost.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (!reset_n || ctr_clear)
        ctr_q[i] <= '0;
      else if ((CTR_READ_CLEAR != 0) && rd_fire && ctr_sel[i])
        ctr_q[i] <= CTR_WIDTH'(evt[i]);
      else if (evt[i])
        ctr_q[i] <= ctr_q[i] + CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csr_wr_en   <= '0;
      csr_wr_data <= '0;
    end else begin
      csr_wr_en <= wr_fire ? test_sel : '0;
      if (wr_fire) csr_wr_data <= s0_wdata;
    end
  end

  logic [72:0]      q_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   q_count;
  logic             q_empty, q_full, pop, bypass, push_req, push, drop;

  assign q_empty  = (q_count == '0);
  assign q_full   = (q_count == (PTR_W+1)'(RSP_FIFO_DEPTH));
  assign pop      = !afu_rsp_valid && !q_empty;
  // An empty queue with an idle AFU lets the local read skip the queue entirely.
  assign bypass   = rd_fire && !afu_rsp_valid && q_empty;
  assign push_req = rd_fire && !bypass;
  assign push     = push_req && (!q_full || pop);
  assign drop     = push_req && q_full && !pop;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {s0_tid, rd_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_count <= q_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid    <= 1'b0;
      rsp_tid      <= '0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      rsp_valid <= afu_rsp_valid || pop || bypass;
      if (afu_rsp_valid)  {rsp_tid, rsp_data} <= {afu_rsp_tid, afu_rsp_data};
      else if (pop)       {rsp_tid, rsp_data} <= q_mem[rd_ptr];
      else if (bypass)    {rsp_tid, rsp_data} <= {s0_tid, rd_data};
      if (drop) rsp_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_test_csrs_mux.sv
// Directed bench for cci_test_csrs_mux: read-map table, counters, read-clear,
// write strobes, AFU/local response merge and queue overflow.
module tb_cci_test_csrs_mux;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mmio_valid, rc_valid, mmio_is_read;
  logic [15:0]  mmio_addr;
  logic [8:0]   mmio_tid;
  logic [63:0]  mmio_wdata;
  logic         afu_rsp_valid;
  logic [8:0]   afu_rsp_tid;
  logic [63:0]  afu_rsp_data;
  logic         rsp_valid, rc_rsp_valid;
  logic [8:0]   rsp_tid, rc_rsp_tid;
  logic [63:0]  rsp_data, rc_rsp_data;
  logic [6:0]   evt, rc_evt;
  logic [511:0] csr_rd_data;
  logic [7:0]   csr_wr_en, rc_csr_wr_en;
  logic [63:0]  csr_wr_data, rc_csr_wr_data;
  logic         rsp_overflow, rc_overflow;
  logic         afu_idle_valid = 1'b0;
  logic [8:0]   afu_idle_tid = '0;
  logic [63:0]  afu_idle_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b1;
  logic [72:0] exp_q[$];

  cci_test_csrs_mux dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_valid(mmio_valid), .mmio_is_read(mmio_is_read), .mmio_addr(mmio_addr),
    .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .afu_rsp_valid(afu_rsp_valid), .afu_rsp_tid(afu_rsp_tid), .afu_rsp_data(afu_rsp_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .evt(evt), .csr_rd_data(csr_rd_data),
    .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .rsp_overflow(rsp_overflow)
  );

  cci_test_csrs_mux #(.CTR_READ_CLEAR(1)) dut_rc (
    .clk(clk), .reset_n(reset_n),
    .mmio_valid(rc_valid), .mmio_is_read(mmio_is_read), .mmio_addr(mmio_addr),
    .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .afu_rsp_valid(afu_idle_valid), .afu_rsp_tid(afu_idle_tid), .afu_rsp_data(afu_idle_data),
    .rsp_valid(rc_rsp_valid), .rsp_tid(rc_rsp_tid), .rsp_data(rc_rsp_data),
    .evt(rc_evt), .csr_rd_data(csr_rd_data),
    .csr_wr_en(rc_csr_wr_en), .csr_wr_data(rc_csr_wr_data), .rsp_overflow(rc_overflow)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Driver tasks: called and returning 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit rc, input bit is_read, input logic [14:0] idx,
                       input logic [8:0] tid, input logic [63:0] wdata);
    mmio_valid   = !rc;
    rc_valid     = rc;
    mmio_is_read = is_read;
    mmio_addr    = {idx, 1'b0};
    mmio_tid     = tid;
    mmio_wdata   = wdata;
    idle(1);
    mmio_valid = 1'b0;
    rc_valid   = 1'b0;
  endtask

  task automatic read_expect(input logic [14:0] idx, input logic [8:0] tid, input logic [63:0] d);
    exp_q.push_back({tid, d});
    issue(1'b0, 1'b1, idx, tid, 64'h0);
    idle(2);
  endtask

  // Scoreboard: every response from the main instance must match the queue head.
  always @(negedge clk) begin
    if (mon_en && reset_n && rsp_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got tid %h data %h, required no response", rsp_tid, rsp_data);
      end else begin
        logic [72:0] e;
        e = exp_q.pop_front();
        if ({rsp_tid, rsp_data} !== e) begin
          n_fail++;
          $display("FAIL sb_rsp: got %h, required %h", {rsp_tid, rsp_data}, e);
        end
      end
    end
  end

  typedef struct {
    logic [14:0] idx;
    logic        claimed;
    logic [63:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[15];

  initial begin
    vecs[0]  = '{15'd0,   1'b1, 64'h1000_0100_0000_0000};
    vecs[1]  = '{15'd1,   1'b1, 64'ha43d1f18bf214d19};
    vecs[2]  = '{15'd2,   1'b1, 64'h438d6c19ff0c40da};
    vecs[3]  = '{15'd3,   1'b1, 64'h0};
    vecs[4]  = '{15'd4,   1'b1, 64'h0};
    vecs[5]  = '{15'd7,   1'b1, 64'h0};
    vecs[6]  = '{15'd8,   1'b1, 64'd400};
    vecs[7]  = '{15'd9,   1'b1, 64'h0};
    vecs[8]  = '{15'd15,  1'b1, 64'h0};
    vecs[9]  = '{15'd16,  1'b1, 64'h0};
    vecs[10] = '{15'd32,  1'b1, 64'hC0DE0000_5A5A0000};
    vecs[11] = '{15'd38,  1'b1, 64'hC0DE0006_5A5A0006};
    vecs[12] = '{15'd39,  1'b1, 64'hC0DE0007_5A5A0007};
    vecs[13] = '{15'd40,  1'b0, 64'h0};
    vecs[14] = '{15'd100, 1'b0, 64'h0};

    for (int j = 0; j < 8; j++)
      csr_rd_data[64*j +: 64] = {32'hC0DE0000 + 32'(j), 32'h5A5A0000 + 32'(j)};

    reset_n = 1'b0;
    mmio_valid = 1'b0; rc_valid = 1'b0; mmio_is_read = 1'b0;
    mmio_addr = '0; mmio_tid = '0; mmio_wdata = '0;
    afu_rsp_valid = 1'b0; afu_rsp_tid = '0; afu_rsp_data = '0;
    evt = '0; rc_evt = '0;
    idle(3);
    check("reset_rsp_valid", 73'(rsp_valid), 73'(0));
    check("reset_rsp_tid_data", {rsp_tid, rsp_data}, 73'(0));
    check("reset_wr_en", 73'(csr_wr_en), 73'(0));
    check("reset_wr_data", 73'(csr_wr_data), 73'(0));
    check("reset_overflow", 73'(rsp_overflow), 73'(0));
    reset_n = 1'b1;
    idle(2);

    // Read-map table with latency and claim checks
    for (int i = 0; i < 15; i++) begin
      logic [8:0] tid;
      tid = 9'(i + 16);
      if (vecs[i].claimed) exp_q.push_back({tid, vecs[i].exp});
      issue(1'b0, 1'b1, vecs[i].idx, tid, 64'h0);
      check($sformatf("lat1_idx%0d", vecs[i].idx), 73'(rsp_valid), 73'(0));
      idle(1);
      check($sformatf("lat2_idx%0d", vecs[i].idx), 73'(rsp_valid), 73'(vecs[i].claimed));
      if (vecs[i].claimed) check($sformatf("tid_idx%0d", vecs[i].idx), 73'(rsp_tid), 73'(tid));
      idle(1);
    end

    // Back-to-back reads, one per cycle
    exp_q.push_back({9'h101, 64'ha43d1f18bf214d19});
    exp_q.push_back({9'h102, 64'h438d6c19ff0c40da});
    exp_q.push_back({9'h103, 64'd400});
    exp_q.push_back({9'h104, 64'h1000_0100_0000_0000});
    issue(1'b0, 1'b1, 15'd1, 9'h101, 64'h0);
    issue(1'b0, 1'b1, 15'd2, 9'h102, 64'h0);
    issue(1'b0, 1'b1, 15'd8, 9'h103, 64'h0);
    issue(1'b0, 1'b1, 15'd0, 9'h104, 64'h0);
    idle(4);

    // Event counter count, clear, and clear-beats-increment
    evt[0] = 1'b1; idle(5); evt[0] = 1'b0;
    read_expect(15'd9, 9'd40, 64'd5);
    issue(1'b0, 1'b0, 15'd7, 9'd0, 64'h1);
    idle(2);
    read_expect(15'd9, 9'd41, 64'd0);
    evt[0] = 1'b1; idle(2); evt[0] = 1'b0;
    issue(1'b0, 1'b0, 15'd7, 9'd0, 64'h1);
    evt[0] = 1'b1; idle(1); evt[0] = 1'b0;
    idle(1);
    read_expect(15'd9, 9'd42, 64'd0);
    evt[1] = 1'b1; idle(3); evt[1] = 1'b0;
    issue(1'b0, 1'b0, 15'd7, 9'd0, 64'h2);
    idle(2);
    read_expect(15'd10, 9'd43, 64'd3);

    // Read-clear instance: pre-clear value returned, concurrent event kept
    rc_evt[0] = 1'b1; idle(3); rc_evt[0] = 1'b0;
    issue(1'b1, 1'b1, 15'd9, 9'd7, 64'h0);
    rc_evt[0] = 1'b1; idle(1); rc_evt[0] = 1'b0;
    check("rc_first_valid", 73'(rc_rsp_valid), 73'(1));
    check("rc_first", {rc_rsp_tid, rc_rsp_data}, {9'd7, 64'd3});
    idle(1);
    issue(1'b1, 1'b1, 15'd9, 9'd8, 64'h0);
    idle(1);
    check("rc_second", {rc_rsp_tid, rc_rsp_data}, {9'd8, 64'd1});
    idle(1);
    issue(1'b1, 1'b1, 15'd9, 9'd9, 64'h0);
    idle(1);
    check("rc_third", {rc_rsp_tid, rc_rsp_data}, {9'd9, 64'd0});
    idle(1);

    // Write strobes
    issue(1'b0, 1'b0, 15'd33, 9'd0, 64'hDEADBEEF);
    check("wr33_early", 73'(csr_wr_en), 73'(0));
    idle(1);
    check("wr33_en", 73'(csr_wr_en), 73'(8'b0000_0010));
    check("wr33_data", 73'(csr_wr_data), 73'(64'hDEADBEEF));
    idle(1);
    check("wr33_pulse", 73'(csr_wr_en), 73'(0));
    issue(1'b0, 1'b0, 15'd39, 9'd0, 64'h55);
    idle(1);
    check("wr39_en", 73'(csr_wr_en), 73'(8'b1000_0000));
    check("wr39_data", 73'(csr_wr_data), 73'(64'h55));
    issue(1'b0, 1'b0, 15'd40, 9'd0, 64'h77);
    check("wr40_c1", 73'(csr_wr_en), 73'(0));
    idle(1);
    check("wr40_c2", 73'(csr_wr_en), 73'(0));
    issue(1'b0, 1'b0, 15'd1, 9'd0, 64'h77);
    idle(1);
    check("wr_ro_idx1", 73'(csr_wr_en), 73'(0));
    idle(1);

    // AFU response collides with a local read: AFU first, local next cycle
    exp_q.push_back({9'd9, 64'h1234_5678_9ABC_DEF0});
    exp_q.push_back({9'd5, 64'ha43d1f18bf214d19});
    issue(1'b0, 1'b1, 15'd1, 9'd5, 64'h0);
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'd9; afu_rsp_data = 64'h1234_5678_9ABC_DEF0;
    idle(1);
    afu_rsp_valid = 1'b0;
    check("merge_afu_first", 73'(rsp_tid), 73'(9'd9));
    idle(1);
    check("merge_local_next", {rsp_valid, rsp_tid}, 73'({1'b1, 9'd5}));
    check("merge_no_overflow", 73'(rsp_overflow), 73'(0));
    idle(2);

    // Queue overflow while the AFU holds the return path
    mon_en = 1'b0;
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h1FF; afu_rsp_data = 64'h0;
    for (int k = 1; k <= 5; k++) issue(1'b0, 1'b1, 15'd8, 9'(k), 64'h0);
    idle(2);
    afu_rsp_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check($sformatf("ovf_rsp%0d", k), {rsp_valid, rsp_tid, rsp_data}, {1'b1, 9'(k), 64'd400});
    end
    idle(1);
    check("ovf_dropped", 73'(rsp_valid), 73'(0));
    check("ovf_flag", 73'(rsp_overflow), 73'(1));
    idle(3);
    check("ovf_sticky", 73'(rsp_overflow), 73'(1));
    reset_n = 1'b0;
    idle(1);
    check("ovf_reset", 73'(rsp_overflow), 73'(0));
    reset_n = 1'b1;
    idle(1);

    // Reset while a local read is in flight discards it
    issue(1'b0, 1'b1, 15'd8, 9'd77, 64'h0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_reset_quiet%0d", k), 73'(rsp_valid), 73'(0));
      idle(1);
    end
    mon_en = 1'b1;
    read_expect(15'd2, 9'd78, 64'h438d6c19ff0c40da);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    check("sb_drained", 73'(exp_q.size()), 73'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
